// File: rtl/print_output_fifo.sv
// First-word-fall-through print buffer between io_output_arbiter and chip_controller.
// Optional PRINT_FIFO_STATS_EN adds drop_count and peak_level statistics outputs.
module print_output_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_en,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop_ack,
    output logic [DATA_W-1:0]        head_data,
    output logic                     head_valid,
    output logic                     almost_full,
    output logic                     full,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic [$clog2(DEPTH):0]   level
`ifdef PRINT_FIFO_STATS_EN
    ,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   peak_level
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LW-1:0]     level_next;
    logic              do_push;
    logic              do_pop;
    logic              drop;

    // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
    assign do_pop  = pop_ack && head_valid;
    assign do_push = push_en && (!full || do_pop);
    assign drop    = push_en && full && !pop_ack;

    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            head_valid  <= 1'b0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level       <= level_next;
            head_valid  <= (level_next != '0);
            full        <= (level_next == LW'(DEPTH));
            almost_full <= (level_next >= LW'(AF_LVL));
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef PRINT_FIFO_STATS_EN
    // A clear coinciding with a drop or level change restarts from that event, not from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
            peak_level <= '0;
        end else begin
            if (clr_overflow) begin
                drop_count <= drop ? 16'd1 : 16'd0;
                peak_level <= level_next;
            end else begin
                if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
                if (level_next > peak_level)        peak_level <= level_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_print_output_fifo.sv
// Directed self-checking bench for print_output_fifo (DEPTH=8, AF_LVL=6).
// Statistics outputs are checked only when PRINT_FIFO_STATS_EN is defined.
`timescale 1ns/1ps
module tb_print_output_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_en = 1'b0;
    logic [31:0] push_data = '0;
    logic        pop_ack = 1'b0;
    logic        clr_overflow = 1'b0;
    logic [31:0] head_data;
    logic        head_valid;
    logic        almost_full;
    logic        full;
    logic        overflow;
    logic [3:0]  level;
`ifdef PRINT_FIFO_STATS_EN
    logic [15:0] drop_count;
    logic [3:0]  peak_level;
`endif

    int n_checks = 0;
    int n_errors = 0;

    print_output_fifo #(.DATA_W(32), .DEPTH(8), .AF_LVL(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .push_en      (push_en),
        .push_data    (push_data),
        .pop_ack      (pop_ack),
        .head_data    (head_data),
        .head_valid   (head_valid),
        .almost_full  (almost_full),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .level        (level)
`ifdef PRINT_FIFO_STATS_EN
        ,
        .drop_count   (drop_count),
        .peak_level   (peak_level)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic [1:0]  ops [20] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd1,
                              2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd2, 2'd1, 2'd1};

    initial begin
        // 1: reset with pushes active
        #2 rst = 1'b1;
        push_en = 1'b1;
        push_data = 32'h1234_5678;
        repeat (3) tick();
        check("rst_level_during", {28'd0, level}, 32'd0);
        push_en = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_head_valid", {31'd0, head_valid}, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_af", {31'd0, almost_full}, 32'd0);
        check("rst_head_data", head_data, 32'd0);

        // 2: three back-to-back pushes, then three pops
        push_en = 1'b1;
        push_data = 32'hDEAD_0001;
        tick();
        check("t2_first_valid", {31'd0, head_valid}, 32'd1);
        check("t2_first_head", head_data, 32'hDEAD_0001);
        push_data = 32'hDEAD_0002;
        tick();
        push_data = 32'hDEAD_0003;
        tick();
        push_en = 1'b0;
        check("t2_level3", {28'd0, level}, 32'd3);
        check("t2_head_kept", head_data, 32'hDEAD_0001);
        pop_ack = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check("t2_pop_data", head_data, 32'hDEAD_0000 + i);
            tick();
        end
        pop_ack = 1'b0;
        check("t2_empty_valid", {31'd0, head_valid}, 32'd0);
        check("t2_empty_level", {28'd0, level}, 32'd0);
        check("t2_empty_head", head_data, 32'd0);

        // 3: fill, drop, sticky overflow, set beats clear
        push_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_data = i;
            tick();
        end
        check("t3_full", {31'd0, full}, 32'd1);
        check("t3_level8", {28'd0, level}, 32'd8);
        check("t3_af", {31'd0, almost_full}, 32'd1);
        check("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
        push_data = 32'h99;
        tick();
        check("t3_ovf_set", {31'd0, overflow}, 32'd1);
        check("t3_level_after_drop", {28'd0, level}, 32'd8);
        push_data = 32'h98;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        push_en = 1'b0;
        check("t3_set_beats_clr", {31'd0, overflow}, 32'd1);
`ifdef PRINT_FIFO_STATS_EN
        check("t3_drop_count", {16'd0, drop_count}, 32'd1);
        check("t3_peak", {28'd0, peak_level}, 32'd8);
`endif
        pop_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_pop_data", head_data, i);
            tick();
        end
        pop_ack = 1'b0;
        check("t3_drained", {28'd0, level}, 32'd0);
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
`ifdef PRINT_FIFO_STATS_EN
        check("t3_drop_cleared", {16'd0, drop_count}, 32'd0);
        check("t3_peak_cleared", {28'd0, peak_level}, 32'd0);
`endif

        // 4: full FIFO, simultaneous push and pop
        push_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_data = i;
            tick();
        end
        push_data = 32'hA;
        pop_ack = 1'b1;
        tick();
        push_en = 1'b0;
        check("t4_level8", {28'd0, level}, 32'd8);
        check("t4_no_ovf", {31'd0, overflow}, 32'd0);
        check("t4_full", {31'd0, full}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("t4_pop_data", head_data, (i == 8) ? 32'hA : i);
            tick();
        end
        pop_ack = 1'b0;
        check("t4_drained", {28'd0, level}, 32'd0);

        // 5: push with pop_ack on empty, then pops on empty
        push_en = 1'b1;
        pop_ack = 1'b1;
        push_data = 32'h5;
        tick();
        push_en = 1'b0;
        pop_ack = 1'b0;
        check("t5_level1", {28'd0, level}, 32'd1);
        check("t5_head", head_data, 32'h5);
        pop_ack = 1'b1;
        tick();
        tick();
        pop_ack = 1'b0;
        check("t5_empty_level", {28'd0, level}, 32'd0);
        check("t5_empty_valid", {31'd0, head_valid}, 32'd0);
        check("t5_no_ovf", {31'd0, overflow}, 32'd0);

        // 6: interleaved traffic against a scoreboard queue
        for (int i = 0; i < 20; i++) begin
            push_en = ops[i][1];
            pop_ack = ops[i][0];
            push_data = 32'hC0DE_0000 + i;
            tick();
            if (ops[i][0] && q.size() > 0) void'(q.pop_front());
            if (ops[i][1]) q.push_back(32'hC0DE_0000 + i);
            check("t6_level", {28'd0, level}, q.size());
            check("t6_af", {31'd0, almost_full}, (q.size() >= 6) ? 32'd1 : 32'd0);
            if (q.size() > 0) check("t6_head", head_data, q[0]);
        end
        pop_ack = 1'b0;
        push_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_data = 32'hBEEF_0000 + i;
            tick();
            q.push_back(32'hBEEF_0000 + i);
            check("t6_af_rise", {31'd0, almost_full}, (q.size() >= 6) ? 32'd1 : 32'd0);
        end
        push_en = 1'b0;
        check("t6_level6", {28'd0, level}, 32'd6);
        pop_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("t6_pop_head", head_data, q[0]);
            void'(q.pop_front());
            tick();
            check("t6_af_fall", {31'd0, almost_full}, 32'd0);
        end
        pop_ack = 1'b0;
        check("t6_level4", {28'd0, level}, 32'd4);
        rst = 1'b1;
        #1;
        check("t6_async_rst_level", {28'd0, level}, 32'd0);
        check("t6_async_rst_valid", {31'd0, head_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        push_en = 1'b1;
        push_data = 32'h77;
        tick();
        push_en = 1'b0;
        check("t6_post_rst_head", head_data, 32'h77);
        check("t6_post_rst_level", {28'd0, level}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
